// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock meter: default count width and FSM state encoding.
package clk_meter_pkg;

  localparam int WIDTH_DEFAULT = 24;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

endpackage

// File: rtl/clk_meter_sync_edge.sv
// Two-flop synchronizer for the measured signal plus rise/fall detection on the synchronized level.
module SyncEdge
  import clk_meter_pkg::*;
(
  input  logic clkI,
  input  logic enable,
  input  logic dI,
  output logic sO,
  output logic riseO,
  output logic fallO
);

  logic meta;
  logic s;
  logic s_d;

  // Clearing all three flops on reset makes an input that is already high look like a fresh rise.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= dI;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign sO    = s;
  assign riseO = s & ~s_d;
  assign fallO = ~s & s_d;

endmodule

// File: rtl/clk_meter.sv
// Measures period and high time of an asynchronous square wave in clkI cycles.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clkI,
  input  logic             enable,
  input  logic             sigI,
  output logic [WIDTH-1:0] periodO,
  output logic [WIDTH-1:0] highO,
  output logic             validO,
  output logic             timeoutO
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             level;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_latch;
  state_t           state;

  SyncEdge u_sync_edge (
    .clkI   (clkI),
    .enable (enable),
    .dI     (sigI),
    .sO     (level),
    .riseO  (rise),
    .fallO  (fall)
  );

  // A rise closes the running period; saturating the counter instead drops back to waiting
  // for a fresh reference edge so the counter never wraps.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      state    <= WAIT_EDGE;
      cnt      <= '0;
      hi_latch <= '0;
      periodO  <= '0;
      highO    <= '0;
      validO   <= 1'b0;
      timeoutO <= 1'b0;
    end else begin
      validO <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            periodO  <= cnt;
            highO    <= hi_latch;
            validO   <= 1'b1;
            timeoutO <= 1'b0;
            cnt      <= CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            timeoutO <= 1'b1;
            state    <= WAIT_EDGE;
          end else begin
            if (fall && !level) begin
              hi_latch <= cnt;
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Scoreboard bench for clk_meter: a 24-bit and an 8-bit instance driven by independent stimulus.
module tb_clk_meter;

  typedef struct {
    int period;
    int high;
    int tol;
  } exp_t;

  logic        clock;
  logic        enable_a, enable_b;
  logic        sig_a, sig_b;
  logic [23:0] period_a, high_a;
  logic [7:0]  period_b, high_b;
  logic        valid_a, valid_b;
  logic        timeout_a, timeout_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   valid_cnt[2];
  int   last_valid[2];
  int   first_valid[2];
  bit   have_last[2];

  clk_meter #(.WIDTH(24)) dut_a (
    .clkI(clock), .enable(enable_a), .sigI(sig_a),
    .periodO(period_a), .highO(high_a), .validO(valid_a), .timeoutO(timeout_a)
  );

  clk_meter #(.WIDTH(8)) dut_b (
    .clkI(clock), .enable(enable_b), .sigI(sig_b),
    .periodO(period_b), .highO(high_b), .validO(valid_b), .timeoutO(timeout_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint exp, input int tol);
    longint diff;
    vectors++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? sb_a.size() : sb_b.size();
  endfunction

  task automatic pushExp(input int k, input int p, input int h, input int tol);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.tol    = tol;
    if (k == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  task automatic observe(input int k, input logic v, input int per, input int hi,
                         input logic to, input logic en);
    exp_t e;
    if (!en) begin
      have_last[k] = 1'b0;
    end else begin
      if (v) begin
        valid_cnt[k]++;
        if (qsize(k) == 0) begin
          checkOutput($sformatf("spurious_valid_%0d", k), v, 0, 0);
        end else begin
          e = (k == 0) ? sb_a.pop_front() : sb_b.pop_front();
          checkOutput($sformatf("period_%0d", k), per, e.period, e.tol);
          checkOutput($sformatf("high_%0d", k), hi, e.high, e.tol);
          checkOutput($sformatf("timeout_on_valid_%0d", k), to, 0, 0);
          if (have_last[k])
            checkOutput($sformatf("valid_gap_%0d", k), cyc - last_valid[k], e.period, e.tol);
          else
            first_valid[k] = cyc;
        end
        have_last[k]  = 1'b1;
        last_valid[k] = cyc;
      end
      if (to) have_last[k] = 1'b0;
    end
  endtask

  // Outputs are sampled on the falling edge, well away from the register updates.
  always @(negedge clock) begin
    observe(0, valid_a, int'(period_a), int'(high_a), timeout_a, enable_a);
    observe(1, valid_b, int'(period_b), int'(high_b), timeout_b, enable_b);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setSig(input int k, input logic v);
    if (k == 0) sig_a = v;
    else        sig_b = v;
  endtask

  // Every rise after the first closes one full period, so it carries an expectation.
  task automatic applyStimulus(input int k, input int period, input int high, input int count);
    for (int i = 0; i < count; i++) begin
      if (i > 0) pushExp(k, period, high, 0);
      setSig(k, 1'b1);
      step(high);
      setSig(k, 1'b0);
      step(period - high);
    end
  endtask

  task automatic resetSide(input int k);
    if (k == 0) enable_a = 1'b0;
    else        enable_b = 1'b0;
    step(2);
    if (k == 0) enable_a = 1'b1;
    else        enable_b = 1'b1;
  endtask

  task automatic drain(input int k, input string tag);
    int n = 0;
    while (qsize(k) != 0 && n < 100) begin
      step(1);
      n++;
    end
    checkOutput(tag, qsize(k), 0, 0);
  endtask

  task automatic waitTimeoutB(output int waited);
    waited = 0;
    while (!timeout_b && waited < 400) begin
      step(1);
      waited++;
    end
    checkOutput("timeout_seen_b", timeout_b, 1, 0);
  endtask

  initial begin
    int vc;
    int t0;
    int w;
    enable_a = 1'b0;
    enable_b = 1'b0;
    sig_a    = 1'b0;
    sig_b    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_cnt[i]   = 0;
      last_valid[i]  = 0;
      first_valid[i] = 0;
      have_last[i]   = 1'b0;
    end

    step(3);
    checkOutput("rst_period_a", period_a, 0, 0);
    checkOutput("rst_high_a", high_a, 0, 0);
    checkOutput("rst_valid_a", valid_a, 0, 0);
    checkOutput("rst_timeout_a", timeout_a, 0, 0);
    checkOutput("rst_period_b", period_b, 0, 0);
    checkOutput("rst_timeout_b", timeout_b, 0, 0);
    enable_a = 1'b1;
    enable_b = 1'b1;
    step(2);

    // Period 10 / high 4: first rise only arms, later rises report 10/4.
    vc = valid_cnt[0];
    t0 = cyc;
    applyStimulus(0, 10, 4, 6);
    drain(0, "drain_10_4");
    checkOutput("count_10_4", valid_cnt[0] - vc, 5, 0);
    checkOutput("latency_a", first_valid[0] - t0, 13, 0);

    // Fastest input: high 1 / low 1, valid every other cycle.
    resetSide(0);
    vc = valid_cnt[0];
    applyStimulus(0, 2, 1, 8);
    drain(0, "drain_2_1");
    checkOutput("count_2_1", valid_cnt[0] - vc, 7, 0);

    // Reset in the middle of a 12/6 period discards it and forces a re-arm.
    resetSide(0);
    applyStimulus(0, 12, 6, 2);
    pushExp(0, 12, 6, 0);
    sig_a = 1'b1;
    step(6);
    sig_a = 1'b0;
    step(3);
    enable_a = 1'b0;
    #1;
    checkOutput("mid_rst_period_a", period_a, 0, 0);
    checkOutput("mid_rst_high_a", high_a, 0, 0);
    checkOutput("mid_rst_valid_a", valid_a, 0, 0);
    checkOutput("mid_rst_timeout_a", timeout_a, 0, 0);
    checkOutput("mid_rst_queue_a", qsize(0), 0, 0);
    step(2);
    enable_a = 1'b1;
    vc = valid_cnt[0];
    applyStimulus(0, 12, 6, 3);
    drain(0, "drain_12_6");
    checkOutput("count_12_6", valid_cnt[0] - vc, 2, 0);

    // 8-bit instance: stuck low after two rises times out 255 cycles after the last valid.
    applyStimulus(1, 20, 7, 2);
    drain(1, "drain_20_7_first");
    waitTimeoutB(w);
    checkOutput("timeout_latency_b", cyc - last_valid[1], 255, 0);
    checkOutput("timeout_keep_period_b", period_b, 20, 0);
    checkOutput("timeout_keep_high_b", high_b, 7, 0);
    vc = valid_cnt[1];
    applyStimulus(1, 20, 7, 3);
    drain(1, "drain_20_7_second");
    checkOutput("count_20_7", valid_cnt[1] - vc, 2, 0);
    checkOutput("timeout_cleared_b", timeout_b, 0, 0);

    // Input held high across reset release: one re-arm rise, then a stuck-high timeout.
    sig_b = 1'b1;
    enable_b = 1'b0;
    step(3);
    vc = valid_cnt[1];
    enable_b = 1'b1;
    t0 = cyc;
    waitTimeoutB(w);
    checkOutput("stuck_high_latency_b", cyc - t0, 258, 0);
    checkOutput("stuck_high_no_valid_b", valid_cnt[1] - vc, 0, 0);
    sig_b = 1'b0;

    // Asynchronous input, edges 0.3 cycle after the clock edge, period 1000 / high 250.
    resetSide(0);
    @(posedge clock);
    #3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pushExp(0, 1000, 250, 1);
      sig_a = 1'b1;
      #2500;
      sig_a = 1'b0;
      #7500;
    end
    drain(0, "drain_async");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
